// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side keyboard transmitter: byte FIFO in front of an 11-bit
// frame serialiser driving open-drain-style clock/data lines.
module ps2_kbd_tx #(
  parameter int unsigned PS2DIV     = 1103,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [7:0] kbd_data,
  input  logic       kbd_wr,
  input  logic       host_inhibit,
  output logic       kbd_full,
  output logic       kbd_empty,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk_out,
  output logic       ps2_data_out
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [15:0] DIV_LAST = 16'(PS2DIV - 1);

  typedef enum logic [1:0] {IDLE, BIT_H, BIT_L, GAP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [7:0]       head;
  logic             push;
  logic             pop;
  logic [15:0]      div;
  logic [3:0]       bit_cnt;
  logic [9:0]       shift;
  logic             gap_half;
  logic             div_done;

  assign head     = mem[rd_ptr];
  assign push     = kbd_wr && (count != CNT_W'(FIFO_DEPTH));
  assign pop      = (state == IDLE) && (count != '0) && !host_inhibit;
  assign div_done = (div == DIV_LAST);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  // Storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= kbd_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      kbd_empty <= 1'b1;
      kbd_full  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      kbd_empty <= (count_nxt == '0);
      kbd_full  <= (count_nxt == CNT_W'(FIFO_DEPTH));
      if (kbd_wr && !push) overflow <= 1'b1;
    end
  end

  // Frame serialiser; shift holds frame bits 1..10, the start bit is driven on load.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      div          <= '0;
      bit_cnt      <= '0;
      shift        <= '1;
      gap_half     <= 1'b0;
      busy         <= 1'b0;
      ps2_clk_out  <= 1'b1;
      ps2_data_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift        <= {1'b1, ~^head, head};
            bit_cnt      <= '0;
            div          <= '0;
            busy         <= 1'b1;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b0;
            state        <= BIT_H;
          end
        end
        BIT_H: begin
          if (div_done) begin
            div         <= '0;
            ps2_clk_out <= 1'b0;
            state       <= BIT_L;
          end else begin
            div <= div + 16'd1;
          end
        end
        BIT_L: begin
          if (div_done) begin
            div         <= '0;
            ps2_clk_out <= 1'b1;
            if (bit_cnt == 4'd10) begin
              gap_half     <= 1'b0;
              ps2_data_out <= 1'b1;
              state        <= GAP;
            end else begin
              bit_cnt      <= bit_cnt + 4'd1;
              ps2_data_out <= shift[0];
              shift        <= {1'b1, shift[9:1]};
              state        <= BIT_H;
            end
          end else begin
            div <= div + 16'd1;
          end
        end
        GAP: begin
          // Two PS2DIV periods keep the divider at 16 bits for any legal PS2DIV.
          if (div_done) begin
            div <= '0;
            if (gap_half) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_half <= 1'b1;
            end
          end else begin
            div <= div + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: a line monitor decodes frames, the main
// sequence compares them against a queue of bytes expected on the wire.
module tb_ps2_kbd_tx;

  localparam int unsigned DIV = 4;

  typedef struct {
    logic [10:0] bits;
    int          t;
  } frame_t;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [7:0] kbd_data;
  logic       kbd_wr;
  logic       host_inhibit;
  logic       kbd_full;
  logic       kbd_empty;
  logic       busy;
  logic       overflow;
  logic       ps2_clk_out;
  logic       ps2_data_out;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         glitches = 0;
  logic [7:0] exp_q [$];
  frame_t     rcvd [$];

  ps2_kbd_tx #(.PS2DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kbd_data(kbd_data), .kbd_wr(kbd_wr),
    .host_inhibit(host_inhibit), .kbd_full(kbd_full), .kbd_empty(kbd_empty),
    .busy(busy), .overflow(overflow), .ps2_clk_out(ps2_clk_out),
    .ps2_data_out(ps2_data_out)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Receiver model: sample data on each falling PS/2 clock edge.
  initial begin
    int          nb;
    int          t0;
    logic [10:0] b;
    nb = 0;
    t0 = 0;
    b  = '0;
    forever begin
      @(negedge ps2_clk_out or negedge reset_n);
      if (!reset_n) begin
        nb = 0;
      end else begin
        if (nb == 0) t0 = cyc;
        b[nb] = ps2_data_out;
        nb++;
        if (nb == 11) begin
          rcvd.push_back('{bits: b, t: t0});
          nb = 0;
        end
      end
    end
  end

  // Data must stay put while the PS/2 clock is low.
  initial begin
    logic pc;
    logic pd;
    pc = 1'b1;
    pd = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (reset_n === 1'b1 && !pc && !ps2_clk_out && ps2_data_out !== pd) glitches++;
      pc = ps2_clk_out;
      pd = ps2_data_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    kbd_data = b;
    kbd_wr   = 1'b1;
    if (accept) exp_q.push_back(b);
    tick();
    kbd_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chkb({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_frame(input string tag, output logic [10:0] bits, output int t);
    frame_t     f;
    logic [7:0] e;
    int         n;
    n    = 0;
    bits = '0;
    t    = 0;
    while (rcvd.size() == 0 && n < 2000) begin
      tick();
      n++;
    end
    chkb({tag, "_arrive"}, rcvd.size() != 0, 1'b1);
    chkb({tag, "_expected"}, exp_q.size() != 0, 1'b1);
    if (rcvd.size() != 0 && exp_q.size() != 0) begin
      f    = rcvd.pop_front();
      e    = exp_q.pop_front();
      bits = f.bits;
      t    = f.t;
      chkb({tag, "_start"}, f.bits[0], 1'b0);
      chk({tag, "_data"}, 32'(f.bits[8:1]), 32'(e));
      chkb({tag, "_parity"}, f.bits[9], ~^e);
      chkb({tag, "_stop"}, f.bits[10], 1'b1);
    end
  endtask

  initial begin
    logic [10:0] fa;
    logic [10:0] fb;
    int          ta;
    int          tb;
    int          n;

    reset_n      = 1'b0;
    kbd_wr       = 1'b0;
    kbd_data     = 8'h00;
    host_inhibit = 1'b0;
    #22;
    chkb("rst_clk", ps2_clk_out, 1'b1);
    chkb("rst_data", ps2_data_out, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ovf", overflow, 1'b0);
    chkb("rst_empty", kbd_empty, 1'b1);
    chkb("rst_full", kbd_full, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single byte 0x1C: latency, first fall, busy length, raw bits.
    wr(8'h1C, 1'b1);
    chkb("lat_empty", kbd_empty, 1'b0);
    chkb("lat_busy0", busy, 1'b0);
    tick();
    chkb("lat_busy1", busy, 1'b1);
    chkb("lat_start", ps2_data_out, 1'b0);
    repeat (DIV - 1) tick();
    chkb("fall_not_yet", ps2_clk_out, 1'b1);
    tick();
    chkb("first_fall", ps2_clk_out, 1'b0);
    n = DIV;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("busy_len", 32'(n), 32'(24 * DIV));
    check_frame("b1c", fa, ta);
    chk("b1c_bits", 32'(fa), 32'(11'b10000111000));

    // Parity of 0x00 and 0xF0, back-to-back spacing.
    wr(8'h00, 1'b1);
    wr(8'hF0, 1'b1);
    check_frame("p00", fa, ta);
    check_frame("pf0", fb, tb);
    chkb("p00_par1", fa[9], 1'b1);
    chkb("pf0_par1", fb[9], 1'b1);
    chk("b2b_spacing", 32'(tb - ta), 32'(24 * DIV + 1));
    wait_idle("par");

    // Overflow while inhibited.
    host_inhibit = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) wr(8'(i), 1'b1);
    chkb("ovf_full8", kbd_full, 1'b1);
    chkb("ovf_before", overflow, 1'b0);
    wr(8'h09, 1'b0);
    chkb("ovf_set", overflow, 1'b1);
    chkb("ovf_full9", kbd_full, 1'b1);
    chkb("ovf_held", busy, 1'b0);
    host_inhibit = 1'b0;
    for (int i = 0; i < 8; i++) check_frame("ovf", fa, ta);
    wait_idle("ovf");
    chkb("ovf_empty", kbd_empty, 1'b1);
    repeat (50) tick();
    chk("ovf_no_extra", 32'(rcvd.size()), 32'd0);
    chkb("ovf_sticky", overflow, 1'b1);

    // Simultaneous write/pop, then inhibit asserted during bit 3.
    wr(8'hA5, 1'b1);
    wr(8'h3C, 1'b1);
    chkb("sim_busy", busy, 1'b1);
    chkb("sim_empty", kbd_empty, 1'b0);
    chkb("sim_full", kbd_full, 1'b0);
    repeat (26) tick();
    host_inhibit = 1'b1;
    check_frame("inh_a", fa, ta);
    wait_idle("inh_a");
    repeat (40) tick();
    chkb("inh_hold_busy", busy, 1'b0);
    chkb("inh_hold_data", ps2_data_out, 1'b1);
    chkb("inh_hold_empty", kbd_empty, 1'b0);
    chk("inh_hold_none", 32'(rcvd.size()), 32'd0);
    host_inhibit = 1'b0;
    tick();
    chkb("inh_rel_busy", busy, 1'b1);
    chkb("inh_rel_start", ps2_data_out, 1'b0);
    check_frame("inh_b", fb, tb);
    wait_idle("inh_b");
    chkb("inh_empty", kbd_empty, 1'b1);

    // Reset during BIT_L of bit 5 with 3 bytes queued.
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    wr(8'h44, 1'b1);
    repeat (44) tick();
    chkb("mid_low", ps2_clk_out, 1'b0);
    chkb("mid_notempty", kbd_empty, 1'b0);
    reset_n = 1'b0;
    #1;
    chkb("mrst_clk", ps2_clk_out, 1'b1);
    chkb("mrst_data", ps2_data_out, 1'b1);
    chkb("mrst_busy", busy, 1'b0);
    chkb("mrst_empty", kbd_empty, 1'b1);
    chkb("mrst_ovf", overflow, 1'b0);
    exp_q.delete();
    #2;
    reset_n = 1'b1;
    repeat (300) tick();
    chk("mrst_no_frame", 32'(rcvd.size()), 32'd0);
    chkb("mrst_idle", busy, 1'b0);
    chkb("mrst_line", ps2_clk_out, 1'b1);

    chk("glitches", 32'(glitches), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

PS/2 device-side keyboard transmitter: accepts scancode bytes from a system-clock producer (key-matrix scanner, OSD macro injector, autotype), queues them in a small FIFO, and serialises each one as an 11-bit PS/2 frame on open-drain-style clock/data outputs. It is the transmitting end of the two-wire `ps2` bundle consumed by the `lynx48` keyboard receiver, and produces the same line timing as the hps_io keyboard path so either source can drive the core.

## Interface
- `PS2DIV`, 1103: PS/2 half-bit period in `clk_sys` cycles; legal range is 2..65535.
- `FIFO_DEPTH`, 8: number of queued bytes; must be a power of two, ≥2.
- `clk_sys` in 1: system clock. All logic runs on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `kbd_data` in 8: byte to queue.
- `kbd_wr` in 1: single-cycle write strobe for `kbd_data`.
- `host_inhibit` in 1: when high, a new frame must not start.
- `kbd_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `kbd_empty` out 1: FIFO holds 0 bytes.
- `busy` out 1: a frame or the inter-frame gap is in progress.
- `overflow` out 1: sticky flag, set when a write is dropped.
- `ps2_clk_out` out 1: PS/2 clock; idles high.
- `ps2_data_out` out 1: PS/2 data; idles high.

## Operation
- **Reset (async, `reset_n`=0).** Resets the following:
  - FIFO is emptied; state goes to IDLE.
  - Outputs: `ps2_clk_out`=1, `ps2_data_out`=1, `busy`=0, `overflow`=0, `kbd_empty`=1, `kbd_full`=0.
  - Reset mid-frame abandons the frame immediately, with no partial-bit completion.
- **FIFO writes.** `kbd_wr`=1 writes `kbd_data` if the count is < `FIFO_DEPTH` at that edge.
  - When full, the write is dropped and `overflow` is set, even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
- **Frame format.** 11 bits, in this order:
  - start bit = 0;
  - `d[0]`..`d[7]`, LSB first;
  - odd parity = ~^d;
  - stop bit = 1.
- **Bit cell.** Each bit lasts 2·PS2DIV cycles:
  - phase H: `ps2_clk_out`=1 for PS2DIV cycles; `ps2_data_out` updates on the first cycle of H.
  - phase L: `ps2_clk_out`=0 for PS2DIV cycles; data is held.
  - The receiver samples data on the falling clock edge.
- **FSM states:** IDLE, BIT_H, BIT_L, GAP.
  - IDLE: if FIFO is not empty and `host_inhibit`=0, pop the head, load the 11-bit shift register, clear `bit_cnt` and the divider, and go to BIT_H.
  - BIT_H: after PS2DIV cycles, go to BIT_L.
  - BIT_L: after PS2DIV cycles:
    - if `bit_cnt`=10, go to GAP;
    - else increment `bit_cnt`, shift, and go to BIT_H.
  - GAP: `ps2_clk_out`=1 and `ps2_data_out`=1 for 2·PS2DIV cycles, then go to IDLE.
- **`host_inhibit`** is evaluated only in IDLE. Asserting it mid-frame or during GAP has no effect on that frame.
- **`busy`** = (state ≠ IDLE).
- **`overflow`** clears only on reset.

## Timing
- **Write-to-line latency.** `kbd_wr` at edge N, with FIFO empty and IDLE, makes `kbd_empty`=0 after edge N.
  - The pop occurs at edge N+1.
  - `busy`=1 and `ps2_data_out`=0 (start bit) after edge N+1.
  - First `ps2_clk_out` fall comes PS2DIV cycles later.
- **Frame length** is 22·PS2DIV cycles of clock activity plus 2·PS2DIV of GAP: 24·PS2DIV from pop to return to IDLE.
- **Back-to-back frames.** The next pop happens on the first IDLE cycle, so start bits are 24·PS2DIV + 1 cycles apart.
- **Output glitches.** `ps2_clk_out` and `ps2_data_out` are registered and glitch-free. Data never changes while `ps2_clk_out`=0.
- **Divider.** 16-bit, reloaded on every state entry. No drift accumulates across bits.

## Test plan
- **Single byte.** PS2DIV=4; write 0x1C.
  - Data sampled at the 11 falling edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - `ps2_data_out`=0 two edges after the write; first fall 4 cycles later; `busy` high for 96 cycles.
- **Parity.** Write 0x00 then 0xF0 (PS2DIV=4).
  - Parity bits are 1 and 1; stop bit is 1.
  - Start bits are 97 cycles apart.
- **Overflow.** With `host_inhibit`=1, write 0x01..0x09 on consecutive cycles.
  - `kbd_full`=1 after the 8th write; `overflow`=1 after the 9th.
  - Release inhibit: exactly 8 frames, 0x01..0x08, are sent; then `kbd_empty`=1 and `busy`=0.
- **Inhibit timing.**
  - Assert `host_inhibit` during a frame's bit 3: the frame completes unchanged, and no new frame starts while inhibit is held.
  - Deassert: the next frame's start bit appears 1 cycle later.
- **Reset mid-frame.** Pulse `reset_n`=0 during BIT_L of bit 5 with 3 bytes queued.
  - Immediately: `ps2_clk_out`=1, `ps2_data_out`=1, `busy`=0, `kbd_empty`=1.
  - No frame is sent afterward.
- **Simultaneous write/pop.** With 1 byte queued and IDLE, write a new byte on the pop edge.
  - Count stays at 1; both bytes are transmitted in order.
